// File: rtl/cfg_dispatch_pkg.sv
// Shared types for the config dispatcher: field widths, FSM state, frame struct.
// Optional macro CFG_DISPATCH_CHKSUM_EN adds an XOR checksum beat per frame.
package cfg_dispatch_pkg;

    localparam int IWIDTH_P = 32;
    localparam int DATA_W   = 64;
    localparam int WICP_W   = 64;
    localparam int TMPC_W   = 32;
    localparam int POST_W   = 32;
    localparam int CFG_W    = DATA_W + WICP_W + TMPC_W + POST_W;
    localparam int BEATS_P  = (CFG_W + IWIDTH_P - 1) / IWIDTH_P;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PEND    = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // data sits at the LSB end so beat 0 lands in data[31:0]
    typedef struct packed {
        logic [POST_W-1:0] post;
        logic [TMPC_W-1:0] tmpc;
        logic [WICP_W-1:0] wicp;
        logic [DATA_W-1:0] data;
    } cfg_frame_t;

endpackage

// File: rtl/cfg_beat_assembler.sv
// Beat counter, assembly buffer and framing/checksum check for cfg_dispatcher.
// Ports: beat_fire_i/beat_data_i/beat_last_i accepted beat, drain_i discard mode;
//   frame_done_o good frame end, frame_bad_o early last or bad checksum,
//   overrun_o final beat without last, empty_o beat count zero,
//   frame_next_o buffer incl. current beat, frame_buf_o registered buffer.
// With CFG_DISPATCH_CHKSUM_EN each frame has one extra XOR checksum beat.
module cfg_beat_assembler
    import cfg_dispatch_pkg::*;
#(
    parameter int IWIDTH = 32,
    parameter int CWIDTH = 192,
    parameter int BEATS  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat_fire_i,
    input  logic              drain_i,
    input  logic [IWIDTH-1:0] beat_data_i,
    input  logic              beat_last_i,
    output logic              frame_done_o,
    output logic              frame_bad_o,
    output logic              overrun_o,
    output logic              empty_o,
    output logic [CWIDTH-1:0] frame_next_o,
    output logic [CWIDTH-1:0] frame_buf_o
);

`ifdef CFG_DISPATCH_CHKSUM_EN
    localparam int FRAME_BEATS = BEATS + 1;
`else
    localparam int FRAME_BEATS = BEATS;
`endif
    localparam int BUF_W = BEATS * IWIDTH;
    localparam int CNT_W = $clog2(FRAME_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BEATS - 1);
    localparam logic [CNT_W-1:0] PAY_CNT  = CNT_W'(BEATS);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic             take;
    logic             at_end;
    logic             sum_ok;

`ifdef CFG_DISPATCH_CHKSUM_EN
    logic [IWIDTH-1:0] sum_q, sum_d;
`endif

    always_comb begin
        take   = beat_fire_i && !drain_i;
        at_end = (beat_cnt_q == LAST_IDX);
        buf_d  = buf_q;
        if (take && (beat_cnt_q < PAY_CNT)) begin
            buf_d[int'(beat_cnt_q)*IWIDTH +: IWIDTH] = beat_data_i;
        end
`ifdef CFG_DISPATCH_CHKSUM_EN
        sum_ok = (beat_data_i == sum_q);
        sum_d  = sum_q;
        if (take) begin
            if (beat_last_i || at_end) begin
                sum_d = '0;
            end else begin
                sum_d = sum_q ^ beat_data_i;
            end
        end
`else
        sum_ok = 1'b1;
`endif
        beat_cnt_d = beat_cnt_q;
        if (take) begin
            if (beat_last_i || at_end) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
        frame_done_o = take && at_end && beat_last_i && sum_ok;
        frame_bad_o  = take && beat_last_i && !(at_end && sum_ok);
        overrun_o    = take && at_end && !beat_last_i;
    end

    assign empty_o      = (beat_cnt_q == '0);
    assign frame_next_o = buf_d[CWIDTH-1:0];
    assign frame_buf_o  = buf_q[CWIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            buf_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            buf_q      <= buf_d;
        end
    end

`ifdef CFG_DISPATCH_CHKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

// File: rtl/cfg_dispatcher.sv
// Collects 32-bit config beats into DATA/WICP/TMPC/POST and hands them to the core.
// Ports: in_* beat stream (valid/ready/last), cfg_valid/cfg_busy core handshake,
//   cfg_*_data fields, frame_err drop pulse, issue_cnt transfers, idle.
// Macro CFG_DISPATCH_CHKSUM_EN enables the per-frame XOR checksum beat.
module cfg_dispatcher
    import cfg_dispatch_pkg::*;
#(
    parameter int IWIDTH      = 32,
    parameter int DATA_CWIDTH = 64,
    parameter int WICP_CWIDTH = 64,
    parameter int TMPC_CWIDTH = 32,
    parameter int POST_CWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IWIDTH-1:0]      in_data,
    input  logic                   in_last,
    output logic                   cfg_valid,
    input  logic                   cfg_busy,
    output logic [DATA_CWIDTH-1:0] cfg_data_data,
    output logic [WICP_CWIDTH-1:0] cfg_wicp_data,
    output logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
    output logic [POST_CWIDTH-1:0] cfg_post_data,
    output logic                   frame_err,
    output logic [15:0]            issue_cnt,
    output logic                   idle
);

    localparam int CWIDTH = DATA_CWIDTH + WICP_CWIDTH
                          + TMPC_CWIDTH + POST_CWIDTH;
    localparam int BEATS  = (CWIDTH + IWIDTH - 1) / IWIDTH;

    state_e      state_q, state_d;
    logic        cfg_valid_q, cfg_valid_d;
    cfg_frame_t  slot_q, slot_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;

    logic              beat_fire;
    logic              xfer;
    logic              frame_done;
    logic              frame_bad;
    logic              overrun;
    logic              asm_empty;
    logic [CWIDTH-1:0] frame_next;
    logic [CWIDTH-1:0] frame_buf;

    assign in_ready  = (state_q != PEND);
    assign beat_fire = in_valid && in_ready;
    assign xfer      = cfg_valid_q && !cfg_busy;

    cfg_beat_assembler #(
        .IWIDTH (IWIDTH),
        .CWIDTH (CWIDTH),
        .BEATS  (BEATS)
    ) u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .beat_fire_i  (beat_fire),
        .drain_i      (state_q == DRAIN),
        .beat_data_i  (in_data),
        .beat_last_i  (in_last),
        .frame_done_o (frame_done),
        .frame_bad_o  (frame_bad),
        .overrun_o    (overrun),
        .empty_o      (asm_empty),
        .frame_next_o (frame_next),
        .frame_buf_o  (frame_buf)
    );

    always_comb begin
        state_d     = state_q;
        cfg_valid_d = cfg_valid_q;
        slot_d      = slot_q;
        frame_err_d = 1'b0;
        issue_cnt_d = issue_cnt_q + {15'd0, xfer};
        if (xfer) begin
            cfg_valid_d = 1'b0;
        end
        case (state_q)
            COLLECT: begin
                if (frame_done) begin
                    // a transfer this cycle frees the slot for a bubble-free reload
                    if (!cfg_valid_q || xfer) begin
                        slot_d      = cfg_frame_t'(frame_next);
                        cfg_valid_d = 1'b1;
                    end else begin
                        state_d = PEND;
                    end
                end else if (overrun) begin
                    frame_err_d = 1'b1;
                    state_d     = DRAIN;
                end else if (frame_bad) begin
                    frame_err_d = 1'b1;
                end
            end
            PEND: begin
                if (xfer) begin
                    slot_d      = cfg_frame_t'(frame_buf);
                    cfg_valid_d = 1'b1;
                    state_d     = COLLECT;
                end
            end
            DRAIN: begin
                if (beat_fire && in_last) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cfg_valid_q <= 1'b0;
            slot_q      <= '0;
            frame_err_q <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_valid_q <= cfg_valid_d;
            slot_q      <= slot_d;
            frame_err_q <= frame_err_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign cfg_valid     = cfg_valid_q;
    assign cfg_data_data = slot_q.data;
    assign cfg_wicp_data = slot_q.wicp;
    assign cfg_tmpc_data = slot_q.tmpc;
    assign cfg_post_data = slot_q.post;
    assign frame_err     = frame_err_q;
    assign issue_cnt     = issue_cnt_q;
    assign idle          = (state_q == COLLECT) && asm_empty && !cfg_valid_q;

endmodule

// File: tb/tb_cfg_dispatcher.sv
// Directed self-checking bench for cfg_dispatcher.
// Define CFG_DISPATCH_CHKSUM_EN to exercise the checksum build.
module tb_cfg_dispatcher;

`ifdef CFG_DISPATCH_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int NB = 6 + int'(CHK);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        cfg_valid;
    logic        cfg_busy = 1'b0;
    logic [63:0] cfg_data_data;
    logic [63:0] cfg_wicp_data;
    logic [31:0] cfg_tmpc_data;
    logic [31:0] cfg_post_data;
    logic        frame_err;
    logic [15:0] issue_cnt;
    logic        idle;

    int errors = 0;
    int checks = 0;
    int err_total = 0;
    logic acc_q = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) acc_q <= in_valid && in_ready;
    always @(negedge clk) if (frame_err) err_total <= err_total + 1;

    cfg_dispatcher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .cfg_valid     (cfg_valid),
        .cfg_busy      (cfg_busy),
        .cfg_data_data (cfg_data_data),
        .cfg_wicp_data (cfg_wicp_data),
        .cfg_tmpc_data (cfg_tmpc_data),
        .cfg_post_data (cfg_post_data),
        .frame_err     (frame_err),
        .issue_cnt     (issue_cnt),
        .idle          (idle)
    );

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        cfg_busy = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // drives one beat and returns 1ns after the edge that accepted it
    task automatic beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc_q && n < 200);
        checks++;
        if (!acc_q) begin
            errors++;
            $display("FAIL beat_accept: beat %h not accepted, got ready=%b want 1", d, in_ready);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 6; k++) begin
            s = s ^ (base + k);
            beat(base + k, (k == 5) && !CHK);
        end
        if (CHK) beat(s, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", cfg_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        checks++; if (issue_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", issue_cnt); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", frame_err); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
        checks++; if (cfg_data_data !== 64'd0) begin errors++; $display("FAIL rst_data: got %h want 0", cfg_data_data); end
        checks++; if (cfg_post_data !== 32'd0) begin errors++; $display("FAIL rst_post: got %h want 0", cfg_post_data); end
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int k = 1; k <= 5; k++) beat(32'(k), 1'b0);
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", cfg_valid); end
        beat(32'd6, !CHK);
        if (CHK) beat(32'd7, 1'b1);
        checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", cfg_valid); end
        checks++; if (cfg_data_data !== 64'h00000002_00000001) begin errors++; $display("FAIL single_data: got %h want 0000000200000001", cfg_data_data); end
        checks++; if (cfg_wicp_data !== 64'h00000004_00000003) begin errors++; $display("FAIL single_wicp: got %h want 0000000400000003", cfg_wicp_data); end
        checks++; if (cfg_tmpc_data !== 32'h5) begin errors++; $display("FAIL single_tmpc: got %h want 5", cfg_tmpc_data); end
        checks++; if (cfg_post_data !== 32'h6) begin errors++; $display("FAIL single_post: got %h want 6", cfg_post_data); end
        @(posedge clk); #1;
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", cfg_valid); end
        checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", issue_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", idle); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg_busy = 1'b1;
        send_frame(32'h10);
        checks++; if (cfg_data_data !== 64'h00000011_00000010) begin errors++; $display("FAIL b2b_a: got %h want 0000001100000010", cfg_data_data); end
        send_frame(32'h20);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_pend: got ready=%b want 0", in_ready); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b want 1", cfg_valid); end
        checks++; if (cfg_data_data !== 64'h00000011_00000010) begin errors++; $display("FAIL b2b_stable: got %h want 0000001100000010", cfg_data_data); end
        checks++; if (issue_cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnt0: got %0d want 0", issue_cnt); end
        cfg_busy = 1'b0;
        @(posedge clk); #1;
        checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL b2b_nobubble: got %b want 1", cfg_valid); end
        checks++; if (cfg_data_data !== 64'h00000021_00000020) begin errors++; $display("FAIL b2b_b: got %h want 0000002100000020", cfg_data_data); end
        checks++; if (cfg_post_data !== 32'h25) begin errors++; $display("FAIL b2b_bpost: got %h want 25", cfg_post_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", cfg_valid); end
        checks++; if (issue_cnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", issue_cnt); end
    endtask

    task automatic test_short_frame();
        do_reset();
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_err: got %b want 1", frame_err); end
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL short_valid: got %b want 0", cfg_valid); end
        @(posedge clk); #1;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_pulse: got %b want 0", frame_err); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL short_idle: got %b want 1", idle); end
        send_frame(32'h30);
        checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL short_next: got %b want 1", cfg_valid); end
        checks++; if (cfg_data_data !== 64'h00000031_00000030) begin errors++; $display("FAIL short_data: got %h want 0000003100000030", cfg_data_data); end
        checks++; if (cfg_post_data !== 32'h35) begin errors++; $display("FAIL short_post: got %h want 35", cfg_post_data); end
    endtask

    task automatic test_overrun();
        int e0;
        do_reset();
        e0 = err_total;
        for (int k = 0; k < NB; k++) beat(32'h50 + 32'(k), 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b want 1", frame_err); end
        beat(32'hdead, 1'b0);
        beat(32'hbeef, 1'b1);
        @(posedge clk); #1;
        checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", err_total - e0); end
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid: got %b want 0", cfg_valid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL ovr_idle: got %b want 1", idle); end
        send_frame(32'h60);
        checks++; if (cfg_data_data !== 64'h00000061_00000060) begin errors++; $display("FAIL ovr_data: got %h want 0000006100000060", cfg_data_data); end
        checks++; if (cfg_tmpc_data !== 32'h64) begin errors++; $display("FAIL ovr_tmpc: got %h want 64", cfg_tmpc_data); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 4; k++) beat(32'h70 + 32'(k), 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mrst_idle: got %b want 1", idle); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(32'h80);
        checks++; if (cfg_data_data !== 64'h00000081_00000080) begin errors++; $display("FAIL mrst_data: got %h want 0000008100000080", cfg_data_data); end
        checks++; if (cfg_post_data !== 32'h85) begin errors++; $display("FAIL mrst_post: got %h want 85", cfg_post_data); end
        @(posedge clk); #1;
        checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL mrst_cnt1: got %0d want 1", issue_cnt); end
        cfg_busy = 1'b1;
        send_frame(32'h90);
        checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL mrst_hold: got %b want 1", cfg_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", cfg_valid); end
        checks++; if (issue_cnt !== 16'd0) begin errors++; $display("FAIL mrst_cnt: got %0d want 0", issue_cnt); end
        checks++; if (cfg_data_data !== 64'd0) begin errors++; $display("FAIL mrst_zero: got %h want 0", cfg_data_data); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cfg_busy = 1'b0;
    endtask

`ifdef CFG_DISPATCH_CHKSUM_EN
    task automatic test_chksum();
        do_reset();
        for (int k = 1; k <= 6; k++) beat(32'(k), 1'b0);
        beat(32'h7, 1'b1);
        checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL chk_good: got %b want 1", cfg_valid); end
        checks++; if (cfg_post_data !== 32'h6) begin errors++; $display("FAIL chk_post: got %h want 6", cfg_post_data); end
        @(posedge clk); #1;
        checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL chk_cnt1: got %0d want 1", issue_cnt); end
        for (int k = 1; k <= 6; k++) beat(32'(k), 1'b0);
        beat(32'h0, 1'b1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL chk_err: got %b want 1", frame_err); end
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL chk_novalid: got %b want 0", cfg_valid); end
        @(posedge clk); #1;
        checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL chk_cnt: got %0d want 1", issue_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL chk_idle: got %b want 1", idle); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_overrun();
        test_mid_reset();
`ifdef CFG_DISPATCH_CHKSUM_EN
        test_chksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
